// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped switch input block: read address selects and default port width.
package io_pkg;

    localparam int IO_WIDTH_DEFAULT = 5;

    // Selects compare against addr[7:2]
    localparam logic [5:0] IO_SEL_PORT0  = 6'b110000;
    localparam logic [5:0] IO_SEL_PORT1  = 6'b110001;
    localparam logic [5:0] IO_SEL_STATUS = 6'b110010;

endpackage

// File: rtl/io_debounce.sv
// One switch port: two-flop synchroniser followed by a tick-driven debouncer.
// chg is a combinational strobe, high in the cycle whose edge loads a new stable value.
module io_debounce
    import io_pkg::*;
#(
    parameter int WIDTH      = IO_WIDTH_DEFAULT,
    parameter int STABLE_CNT = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             tick,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             chg
);

    localparam int CW = $clog2(STABLE_CNT + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_nxt;
    logic [WIDTH-1:0] stable_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             accept;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count of consecutive ticks that have seen cand; saturates once accepted
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (sync2 != cand) begin
            cand_nxt = sync2;
            cnt_nxt  = CW'(1);
        end else if (cnt < CW'(STABLE_CNT)) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    assign accept = tick && (cnt_nxt == CW'(STABLE_CNT)) && (cand_nxt != stable_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cand     <= '0;
            cnt      <= '0;
            stable_q <= '0;
        end else if (tick) begin
            cand <= cand_nxt;
            cnt  <= cnt_nxt;
            if (accept) begin
                stable_q <= cand_nxt;
            end
        end
    end

    assign stable = stable_q;
    assign chg    = accept;

endmodule

// File: rtl/io_input_scan_ctrl.sv
// Switch input scanner for the CPU I/O space: scan prescaler, two debounced ports,
// sticky change flags with read-to-clear, and a registered strobe/ready read port.
module io_input_scan_ctrl
    import io_pkg::*;
#(
    parameter int WIDTH      = IO_WIDTH_DEFAULT,
    parameter int SCAN_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_port0,
    input  logic [WIDTH-1:0] in_port1,
    input  logic [31:0]      addr,
    input  logic             io_rd,
    output logic [31:0]      io_read_data,
    output logic             io_ready,
    output logic             irq
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [WIDTH-1:0] stable0;
    logic [WIDTH-1:0] stable1;
    logic             chg0_set;
    logic             chg1_set;
    logic             chg0_q;
    logic             chg1_q;
    logic [5:0]       sel;
    logic             rd_status;
    logic [31:0]      rd_mux;
    logic             addr_unused;

    assign tick = (pre_cnt == PW'(SCAN_DIV - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    io_debounce #(
        .WIDTH      (WIDTH),
        .STABLE_CNT (STABLE_CNT)
    ) u_db0 (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick),
        .raw    (in_port0),
        .stable (stable0),
        .chg    (chg0_set)
    );

    io_debounce #(
        .WIDTH      (WIDTH),
        .STABLE_CNT (STABLE_CNT)
    ) u_db1 (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick),
        .raw    (in_port1),
        .stable (stable1),
        .chg    (chg1_set)
    );

    assign sel         = addr[7:2];
    assign addr_unused = ^{addr[31:8], addr[1:0]};
    assign rd_status   = io_rd && (sel == IO_SEL_STATUS);

    // A new change arriving on the clearing read wins over the clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chg0_q <= 1'b0;
            chg1_q <= 1'b0;
        end else begin
            chg0_q <= chg0_set | (chg0_q & ~rd_status);
            chg1_q <= chg1_set | (chg1_q & ~rd_status);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            IO_SEL_PORT0:  rd_mux = 32'(stable0);
            IO_SEL_PORT1:  rd_mux = 32'(stable1);
            IO_SEL_STATUS: rd_mux = {30'b0, chg1_q, chg0_q};
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            io_read_data <= '0;
            io_ready     <= 1'b0;
        end else begin
            io_ready <= io_rd;
            if (io_rd) begin
                io_read_data <= rd_mux;
            end
        end
    end

    assign irq = chg0_q | chg1_q;

endmodule

// File: tb/tb_io_input_scan_ctrl.sv
// Scoreboard bench for io_input_scan_ctrl: reads push expected data, a monitor pops on io_ready.
module tb_io_input_scan_ctrl;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  in_port0, in_port1;
    logic [31:0] addr;
    logic        io_rd;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        irq;

    logic [4:0]  f_in0, f_in1;
    logic [31:0] f_data;
    logic        f_ready;
    logic        f_irq;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clock = ~clock;

    io_input_scan_ctrl #(.WIDTH(5), .SCAN_DIV(4), .STABLE_CNT(3)) u_dut (
        .clock        (clock),
        .resetn       (resetn),
        .in_port0     (in_port0),
        .in_port1     (in_port1),
        .addr         (addr),
        .io_rd        (io_rd),
        .io_read_data (io_read_data),
        .io_ready     (io_ready),
        .irq          (irq)
    );

    io_input_scan_ctrl #(.WIDTH(5), .SCAN_DIV(1), .STABLE_CNT(3)) u_dut_fast (
        .clock        (clock),
        .resetn       (resetn),
        .in_port0     (f_in0),
        .in_port1     (f_in1),
        .addr         (32'h0),
        .io_rd        (1'b0),
        .io_read_data (f_data),
        .io_ready     (f_ready),
        .irq          (f_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every io_ready must match the oldest outstanding expectation
    always @(posedge clock) begin
        #1;
        if (io_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got io_ready=1 expected no response");
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_data", io_read_data, mon_exp);
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [31:0] e);
        @(negedge clock);
        io_rd = 1'b1;
        addr  = a;
        exp_q.push_back(e);
        @(negedge clock);
        io_rd = 1'b0;
        addr  = 32'h0;
    endtask

    task automatic wait_irq(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (irq === 1'b1) break;
            @(posedge clock);
            #1;
        end
        check(name, {31'b0, irq}, 32'h1);
    endtask

    initial begin
        resetn   = 1'b0;
        in_port0 = 5'h00;
        in_port1 = 5'h00;
        f_in0    = 5'h00;
        f_in1    = 5'h00;
        addr     = 32'h0;
        io_rd    = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_data", io_read_data, 32'h0);
        check("rst_ready", {31'b0, io_ready}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        resetn = 1'b1;

        // Accept once, then abandon everything with a mid-run reset
        in_port0 = 5'h15;
        wait_irq("accept_pre", 40);
        do_read(32'hC0, 32'h15);
        @(negedge clock);
        io_rd = 1'b1;
        addr  = 32'hC0;
        #2 resetn = 1'b0;
        #1 io_rd = 1'b0;
        addr = 32'h0;
        #1;
        check("midrst_data", io_read_data, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        @(posedge clock);
        #1;
        check("midrst_ready", {31'b0, io_ready}, 32'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        io_rd  = 1'b1;
        addr   = 32'hC0;
        exp_q.push_back(32'h0);
        @(negedge clock);
        io_rd = 1'b0;
        addr  = 32'h0;

        // Accept after reset
        wait_irq("accept", 40);
        do_read(32'hC0, 32'h15);
        do_read(32'hC4, 32'h0);
        do_read(32'hC8, 32'h1);
        check("status_clr_irq", {31'b0, irq}, 32'h0);

        // Glitch on port1 shorter than the debounce window
        @(negedge clock);
        in_port1 = 5'h1F;
        repeat (6) @(negedge clock);
        in_port1 = 5'h00;
        repeat (20) @(negedge clock);
        check("glitch_irq", {31'b0, irq}, 32'h0);
        do_read(32'hC4, 32'h0);

        // Port1 acceptance lands on the status-clear edge; chg1 must survive
        @(negedge clock);
        in_port0 = 5'h0C;
        wait_irq("accept0_b", 40);
        in_port1 = 5'h0A;
        repeat (11) @(posedge clock);
        @(negedge clock);
        io_rd = 1'b1;
        addr  = 32'hC8;
        exp_q.push_back(32'h1);
        @(negedge clock);
        io_rd = 1'b0;
        addr  = 32'h0;
        check("set_wins_irq", {31'b0, irq}, 32'h1);
        do_read(32'hC8, 32'h2);
        check("chg1_clr_irq", {31'b0, irq}, 32'h0);
        do_read(32'hC0, 32'h0C);
        do_read(32'hC4, 32'h0A);

        // Back-to-back reads: unmapped, port0, status
        @(negedge clock);
        io_rd = 1'b1;
        addr  = 32'hD0;
        exp_q.push_back(32'h0);
        @(negedge clock);
        addr = 32'hC0;
        exp_q.push_back(32'h0C);
        @(negedge clock);
        addr = 32'hC8;
        exp_q.push_back(32'h0);
        @(negedge clock);
        io_rd = 1'b0;
        addr  = 32'hC8;
        repeat (3) @(negedge clock);
        addr = 32'h0;

        // Tick-every-cycle build: acceptance exactly 5 edges after the change
        @(posedge clock);
        #1;
        f_in0 = 5'h11;
        repeat (4) @(posedge clock);
        #1;
        check("fast_before", {31'b0, f_irq}, 32'h0);
        @(posedge clock);
        #1;
        check("fast_accept", {31'b0, f_irq}, 32'h1);
        check("fast_no_ready", {31'b0, f_ready}, 32'h0);

        repeat (3) @(negedge clock);
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
